// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller sitting between the
// MEM stage and a line-wide multi-cycle memory; stalls the pipeline while servicing misses.
module dcache_wb_ctrl #(
    parameter int LINES  = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int IDX    = $clog2(LINES);
    localparam int OFF    = $clog2(LINE_W / 8);
    localparam int TAG_W  = 32 - IDX - OFF;
    localparam int WORDS  = LINE_W / 32;
    localparam int WSEL_W = OFF - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [WSEL_W-1:0] word_sel;
    logic [IDX-1:0]    index;
    logic [TAG_W-1:0]  tag;

    assign word_sel = cpu_addr_i[OFF-1:2];
    assign index    = cpu_addr_i[OFF+IDX-1:OFF];
    assign tag      = cpu_addr_i[31:OFF+IDX];

    // Byte-within-word bits are meaningless for word-only accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    logic [LINES-1:0]        valid_reg;
    logic [LINES-1:0]        dirty_reg;
    logic [TAG_W-1:0]        tag_mem [LINES];
    logic [WORDS-1:0][31:0]  lane_rdata;
    logic                    hit;
    logic                    store_hit;
    logic                    refill_done;

    assign hit         = cpu_req_i & valid_reg[index] & (tag_mem[index] == tag);
    assign store_hit   = rst_n_i & (state_reg == IDLE) & hit & cpu_we_i;
    assign refill_done = (state_reg == REFILL) & mem_ack_i;

    // One 32-bit lane per word so a store touches only its own word of the line.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_lane
            logic [31:0] lane_mem [LINES];

            always_ff @(posedge clk_i) begin
                if (refill_done) begin
                    lane_mem[index] <= mem_rdata_i[gi*32 +: 32];
                end else if (store_hit && (word_sel == WSEL_W'(gi))) begin
                    lane_mem[index] <= cpu_wdata_i;
                end
            end

            assign lane_rdata[gi] = lane_mem[index];
        end
    endgenerate

    assign cpu_rdata_o = lane_rdata[word_sel];

    always_ff @(posedge clk_i) begin
        if (refill_done) begin
            tag_mem[index] <= tag;
        end
    end

    // Refill and store hit are mutually exclusive: a store hit only happens in IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (refill_done) begin
            valid_reg[index] <= 1'b1;
            dirty_reg[index] <= 1'b0;
        end else if (store_hit) begin
            dirty_reg[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cpu_stall_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        case (state_reg)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    cpu_stall_o = 1'b1;
                    if (valid_reg[index] && dirty_reg[index]) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = REFILL;
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_mem[index], index, {OFF{1'b0}}};
                mem_wdata_o = lane_rdata;
                if (mem_ack_i) begin
                    state_next = REFILL;
                end
            end
            REFILL: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {tag, index, {OFF{1'b0}}};
                if (mem_ack_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (!rst_n_i) begin
            cpu_stall_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Randomized and directed bench for dcache_wb_ctrl, checked against a transaction-level
// cache/memory model that predicts hits, evictions, memory traffic, stall length and load data.
module tb_dcache_wb_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_ack;

    always #5 clk = ~clk;

    dcache_wb_ctrl #(.LINES(32), .LINE_W(256)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    txn_t obs_q[$];
    txn_t exp_q[$];

    // Behavioural model: backing memory plus the cache contents it should hold.
    logic [255:0] mem_model [logic [31:0]];
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_line  [32];

    function automatic logic [255:0] mem_read(input logic [31:0] a);
        logic [255:0] l;
        if (mem_model.exists(a)) return mem_model[a];
        for (int k = 0; k < 8; k++) begin
            l[k*32 +: 32] = (a + k * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int lw, input int lr, output int stalls, output logic [31:0] rdata);
        logic [4:0]  idx;
        logic [21:0] tg;
        int          w;
        bit          hit;
        bit          wb;
        int          exp_stall;
        logic [31:0] exp_rd;
        logic [31:0] la;
        txn_t        t;
        int          txn_cycles;
        bit          done;
        int          n;

        idx = addr[9:5];
        tg  = addr[31:10];
        w   = int'(addr[4:2]);
        exp_q.delete();
        obs_q.delete();

        hit = m_valid[idx] && (m_tag[idx] == tg);
        wb  = !hit && m_valid[idx] && m_dirty[idx];
        if (wb) begin
            la = {m_tag[idx], idx, 5'b0};
            t  = '{we: 1'b1, addr: la, data: m_line[idx]};
            exp_q.push_back(t);
            mem_model[la] = m_line[idx];
        end
        if (!hit) begin
            la = {tg, idx, 5'b0};
            t  = '{we: 1'b0, addr: la, data: 256'h0};
            exp_q.push_back(t);
            m_line[idx]  = mem_read(la);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        exp_stall = hit ? 0 : (wb ? lw + lr + 1 : lr + 1);
        exp_rd    = m_line[idx][w*32 +: 32];
        if (we) begin
            m_line[idx][w*32 +: 32] = wdata;
            m_dirty[idx] = 1'b1;
        end

        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        stalls     = 0;
        txn_cycles = 0;
        done       = 1'b0;
        rdata      = 32'h0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            #2;
            mem_ack = 1'b0;
            if (!cpu_stall) begin
                rdata = cpu_rdata;
                check_eq("req_idle", mem_req, 1'b0);
                done = 1'b1;
                break;
            end
            stalls++;
            if (mem_req) begin
                if (txn_cycles == 0) begin
                    t = '{we: mem_we, addr: mem_addr, data: mem_wdata};
                    obs_q.push_back(t);
                end
                txn_cycles++;
                if (txn_cycles >= (mem_we ? lw : lr)) begin
                    mem_ack = 1'b1;
                    if (!mem_we) mem_rdata = mem_read(mem_addr);
                    txn_cycles = 0;
                end
            end
            @(negedge clk);
        end
        if (!done) check_eq("timeout", 1'b1, 1'b0);

        check_eq("stall_cycles", stalls, exp_stall);
        check_eq("txn_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq("txn_we", obs_q[i].we, exp_q[i].we);
            check_eq("txn_addr", obs_q[i].addr, exp_q[i].addr);
            if (exp_q[i].we) check_eq("txn_wdata", obs_q[i].data, exp_q[i].data);
        end
        if (!we) check_eq("load_data", rdata, exp_rd);
        $display("access we=%0d addr=%h stall=%0d rdata=%h", we, addr, stalls, rdata);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    initial begin
        int          st;
        logic [31:0] rd;
        logic [255:0] l;
        bit          w;
        logic [31:0] a;

        rst_n     = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_0404;
        cpu_wdata = 32'h0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        #2;
        check_eq("rst_stall", cpu_stall, 1'b0);
        check_eq("rst_mem_req", mem_req, 1'b0);
        @(negedge clk);
        rst_n   = 1'b1;
        cpu_req = 1'b0;

        // Cold load with word1 = DEADBEEF, ack on the 4th request cycle.
        l = mem_read(32'h0000_0400);
        l[63:32] = 32'hDEAD_BEEF;
        mem_model[32'h0000_0400] = l;
        access(1'b0, 32'h0000_0404, 32'h0, 1, 4, st, rd);
        check_eq("cold_stall", st, 5);
        check_eq("cold_rdata", rd, 32'hDEAD_BEEF);

        access(1'b1, 32'h0000_0408, 32'h1234_5678, 1, 1, st, rd);
        check_eq("store_hit_stall", st, 0);
        access(1'b0, 32'h0000_0408, 32'h0, 1, 1, st, rd);
        check_eq("load_hit_stall", st, 0);
        check_eq("load_hit_rdata", rd, 32'h1234_5678);

        // Dirty eviction of index 0 by tag 3.
        access(1'b0, 32'h0000_0C08, 32'h0, 3, 2, st, rd);
        check_eq("dirty_evict_stall", st, 6);
        if (obs_q.size() > 0) check_eq("evict_wb_word2", obs_q[0].data[95:64], 32'h1234_5678);
        else check_eq("evict_wb_present", 1'b0, 1'b1);

        // Clean eviction back to tag 1.
        access(1'b0, 32'h0000_0C08, 32'h0, 1, 1, st, rd);
        access(1'b0, 32'h0000_0408, 32'h0, 2, 2, st, rd);
        check_eq("clean_evict_stall", st, 3);
        check_eq("clean_evict_rdata", rd, 32'h1234_5678);

        // Reset in the middle of a refill.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_2044;
        @(negedge clk);
        @(negedge clk);
        #2;
        check_eq("midrefill_req", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_stall", cpu_stall, 1'b0);
        @(negedge clk);
        #2;
        check_eq("postrst_req", mem_req, 1'b0);
        check_eq("postrst_stall", cpu_stall, 1'b0);
        @(negedge clk);
        rst_n   = 1'b1;
        cpu_req = 1'b0;
        model_reset();
        access(1'b0, 32'h0000_2044, 32'h0, 1, 2, st, rd);
        check_eq("rst_remiss_stall", st, 3);

        // Spurious ack in IDLE with no request.
        @(negedge clk);
        cpu_req = 1'b0;
        mem_ack = 1'b1;
        #2;
        check_eq("spur_req", mem_req, 1'b0);
        @(negedge clk);
        mem_ack = 1'b0;
        #2;
        check_eq("spur_stall", cpu_stall, 1'b0);
        check_eq("spur_req2", mem_req, 1'b0);
        access(1'b0, 32'h0000_0060, 32'h0, 1, 1, st, rd);
        check_eq("spur_miss_stall", st, 2);

        // Random traffic on a few indexes and tags to force conflicts.
        for (int i = 0; i < 200; i++) begin
            a = ($urandom_range(3, 0) << 10) | ($urandom_range(3, 0) << 5) | ($urandom_range(7, 0) << 2);
            w = ($urandom_range(1, 0) == 1);
            access(w, a, $urandom, $urandom_range(4, 1), $urandom_range(4, 1), st, rd);
            if ($urandom_range(3, 0) == 0) idle_cycle();
        end

        idle_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_wb_ctrl.md
Name: dcache_wb_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache. It sits between the pipeline MEM stage (EX_MEM ALU address, store data, MemRead/MemWrite) and a multi-cycle line-wide main memory.
- It returns load data on hits in the same cycle.
- On misses it stalls the whole pipeline while it writes back a dirty victim and refills the line.

Parameters:
- LINES, 32, number of cache lines (power of 2); index width IDX = log2(LINES).
- LINE_W, 256, line width in bits (8 words of 32 bits); offset width OFF = log2(LINE_W/8) = 5.
- TAG_W, 32-IDX-OFF (default 22), tag width; derived, not user-set.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset; synchronous, active-low.
- cpu_req_i  in  1  access request (MemRead | MemWrite from EX_MEM).
- cpu_we_i  in  1  1 = store, 0 = load; valid with cpu_req_i.
- cpu_addr_i  in  32  byte address; bits [1:0] ignored (word accesses only).
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data.
- cpu_stall_o  out  1  freeze PC, IF_ID, ID_EX, EX_MEM and MEM_WB while high.
- mem_req_o  out  1  memory transaction request.
- mem_we_o  out  1  1 = line write-back, 0 = line read.
- mem_addr_o  out  32  line-aligned address, bits [4:0] = 0.
- mem_wdata_o  out  LINE_W  victim line data.
- mem_rdata_i  in  LINE_W  refill line data; valid in the mem_ack_i cycle.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Address split:
  - word select = addr[4:2]
  - index = addr[OFF+IDX-1:OFF]
  - tag = addr[31:OFF+IDX]
- Storage:
  - per-line valid, dirty and tag registers, plus a LINE_W data array.
  - Only valid and dirty are reset; tag and data are not reset.
- hit = cpu_req_i & valid[index] & (tag_arr[index] == tag). This is combinational.
- Load hit:
  - cpu_rdata_o = selected word of the line, in the same cycle, with no stall.
  - When not a load hit, cpu_rdata_o is the selected word of the indexed line (don't-care value, but deterministic, never X after the line has been written).
- Store hit: at the rising edge with cpu_stall_o = 0, write the word into the line and set dirty = 1. No stall.
- Stall: cpu_stall_o = rst_n_i & ((state == IDLE & cpu_req_i & ~hit) | state != IDLE). The CPU holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_wdata_i stable while stalled.
- FSM states: IDLE, WRITEBACK, REFILL.
  - IDLE: on a miss, if valid & dirty at index, go to WRITEBACK; otherwise go to REFILL. With no request, or on a hit, stay in IDLE.
  - WRITEBACK:
    - Drive mem_req_o = 1, mem_we_o = 1, mem_addr_o = {tag_arr[index], index, 5'b0}, mem_wdata_o = victim line.
    - Hold these until the mem_ack_i cycle, then go to REFILL.
  - REFILL:
    - Drive mem_req_o = 1, mem_we_o = 0, mem_addr_o = {tag, index, 5'b0}.
    - In the mem_ack_i cycle: data[index] = mem_rdata_i, tag_arr = tag, valid = 1, dirty = 0; go to IDLE.
  - After returning to IDLE, the held request now hits. Stall drops in that cycle and the load/store completes as a normal hit (a store then sets dirty).
- mem_req_o drops in the cycle after ack. Each transaction needs a fresh assertion (WRITEBACK→REFILL gives mem_req_o low for 0 cycles, but mem_we_o/mem_addr_o change on the state transition edge).
- mem_ack_i while in IDLE is ignored.
- Outside WRITEBACK and REFILL: mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
- Stall cycles per miss:
  - clean miss: Lr + 1
  - dirty miss: Lw + Lr + 1
  - where Lw and Lr = cycles from mem_req_o rise to mem_ack_i, inclusive.
- Reset (rst_n_i = 0 at an edge, any state including mid-transaction):
  - state = IDLE, all valid = 0, all dirty = 0 (dirty data is discarded).
  - mem_req_o = 0 from the next cycle; cpu_stall_o = 0 while rst_n_i = 0.
- Same index, different tag (conflict): the victim is always evicted. There is no replacement choice.
- cpu_req_i deasserting mid-miss is illegal (CPU stalled). Behaviour is unspecified; the bench must not do it.

Test Plan:
- Cold load: after reset, load 0x0000_0404, memory returns a line with word1 = 0xDEAD_BEEF, ack 4 cycles after req → mem_addr_o = 0x0000_0400, mem_we_o = 0; cpu_stall_o high 5 cycles; cpu_rdata_o = 0xDEAD_BEEF in the first unstalled cycle.
- Store hit: store 0x1234_5678 to 0x0000_0408, then load 0x0000_0408 → no stall on either access; read returns 0x1234_5678; dirty[0] = 1.
- Dirty eviction: after the store above, load 0x0000_0C08 (same index 0, tag 3) → WRITEBACK first: mem_we_o = 1, mem_addr_o = 0x0000_0400, mem_wdata_o word2 = 0x1234_5678. Then REFILL at 0x0000_0C00. Stall = Lw + Lr + 1.
- Clean eviction: load 0x0000_0C08 again after the eviction, then load 0x0000_0408 → second load goes straight to REFILL (no WRITEBACK); mem_req_o with mem_we_o = 0 only.
- Reset mid-refill: assert rst_n_i = 0 during REFILL before ack → next cycle mem_req_o = 0, cpu_stall_o = 0; subsequent load of the same address misses again.
- Spurious ack in IDLE with cpu_req_i = 0 → no state change; no valid bit set.
